// File: rtl/pulse_train_gen.sv
// Programmable pulse-train source: a burst of N pulses or a continuous train,
// with clamped high/low phase lengths measured in system clocks.
module pulse_train_gen #(
  parameter int CNT_W     = 32,
  parameter int BURST_W   = 16,
  parameter int MIN_PHASE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   high_len,
  input  logic [BURST_W-1:0] burst_len,
  output logic               pulse_out,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] pulse_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  localparam logic [CNT_W-1:0]   MIN_C  = CNT_W'(MIN_PHASE);
  localparam logic [CNT_W-1:0]   ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   ZERO_C = {CNT_W{1'b0}};
  localparam logic [BURST_W-1:0] ONE_B  = {{(BURST_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] ZERO_B = {BURST_W{1'b0}};

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   h_q, h_d;
  logic [CNT_W-1:0]   l_q, l_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] pcnt_q, pcnt_d;
  logic               pulse_q, pulse_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   start_h_s;
  logic [CNT_W-1:0]   start_l_s;

  function automatic logic [CNT_W-1:0] eff_high(input logic [CNT_W-1:0] hl);
    if (hl < MIN_C) begin
      eff_high = MIN_C;
    end else begin
      eff_high = hl;
    end
  endfunction

  // The comparison is done one bit wider so h + MIN_PHASE cannot wrap.
  function automatic logic [CNT_W-1:0] eff_low(input logic [CNT_W-1:0] per,
                                               input logic [CNT_W-1:0] h);
    logic [CNT_W:0] lim;
    lim = {1'b0, h} + {1'b0, MIN_C};
    if ({1'b0, per} < lim) begin
      eff_low = MIN_C;
    end else begin
      eff_low = per - h;
    end
  endfunction

  assign start_h_s = eff_high(high_len);
  assign start_l_s = eff_low(period, start_h_s);

  // Next-state logic for the phase FSM, counters and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    l_d     = l_q;
    burst_d = burst_q;
    pcnt_d  = pcnt_q;
    pulse_d = pulse_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          h_d     = start_h_s;
          l_d     = start_l_s;
          burst_d = burst_len;
          pcnt_d  = ONE_B;
          cnt_d   = start_h_s - ONE_C;
          pulse_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_HIGH;
        end else begin
          pulse_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_HIGH: begin
        if (stop) begin
          pulse_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == ZERO_C) begin
          cnt_d   = l_q - ONE_C;
          pulse_d = 1'b0;
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      S_LOW: begin
        if (stop) begin
          pulse_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == ZERO_C) begin
          if ((burst_q != ZERO_B) && (pcnt_q == burst_q)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            pcnt_d  = pcnt_q + ONE_B;
            cnt_d   = h_q - ONE_C;
            pulse_d = 1'b1;
            state_d = S_HIGH;
          end
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      default: begin
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= ZERO_C;
      h_q     <= ZERO_C;
      l_q     <= ZERO_C;
      burst_q <= ZERO_B;
      pcnt_q  <= ZERO_B;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      l_q     <= l_d;
      burst_q <= burst_d;
      pcnt_q  <= pcnt_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = pcnt_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: per-cycle comparison against an
// arithmetic timeline model, plus directed checks with literal expectations.
module tb_pulse_train_gen;
  localparam int CW   = 32;
  localparam int BW   = 8;   // narrow pulse counter so the wrap is reachable quickly
  localparam int MINP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] period = '0;
  logic [CW-1:0] high_len = '0;
  logic [BW-1:0] burst_len = '0;
  logic          pulse_out, busy, done;
  logic [BW-1:0] pulse_cnt;

  pulse_train_gen #(.CNT_W(CW), .BURST_W(BW), .MIN_PHASE(MINP)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .period(period), .high_len(high_len), .burst_len(burst_len),
    .pulse_out(pulse_out), .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a train started at edge t0 is a pure function of the edge index.
  longint ecount    = 0;
  bit     m_active  = 1'b0;
  longint m_t0      = 0;
  longint m_h       = 0;
  longint m_l       = 0;
  longint m_n       = 0;
  longint m_hold    = 0;
  longint m_done_at = -1;

  function automatic longint eff_h(input longint hl);
    return (hl < MINP) ? longint'(MINP) : hl;
  endfunction

  function automatic longint eff_l(input longint per, input longint h);
    return (per <= h + MINP - 1) ? longint'(MINP) : per - h;
  endfunction

  function automatic longint m_k(input longint e);
    return (e - m_t0) / (m_h + m_l);
  endfunction

  function automatic longint m_pos(input longint e);
    return (e - m_t0) % (m_h + m_l);
  endfunction

  function automatic bit m_finished(input longint e);
    return (m_n != 0) && (m_k(e) >= m_n);
  endfunction

  function automatic bit m_busy(input longint e);
    return m_active && !m_finished(e);
  endfunction

  function automatic bit m_pulse(input longint e);
    return m_busy(e) && (m_pos(e) < m_h);
  endfunction

  function automatic bit m_done(input longint e);
    if (m_active) return m_finished(e) && (m_k(e) == m_n) && (m_pos(e) == 0);
    else          return e == m_done_at;
  endfunction

  function automatic longint m_cnt(input longint e);
    if (!m_active)          return m_hold;
    else if (m_finished(e)) return m_n;
    else                    return (m_k(e) + 1) % (longint'(1) << BW);
  endfunction

  always @(posedge clk) ecount <= ecount + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active  <= 1'b0;
      m_hold    <= 0;
      m_done_at <= -1;
    end else if (stop && m_busy(ecount)) begin
      m_active  <= 1'b0;
      m_hold    <= m_cnt(ecount);
      m_done_at <= ecount + 1;
    end else if (start && !stop && !m_busy(ecount)) begin
      m_active <= 1'b1;
      m_t0     <= ecount + 1;
      m_h      <= eff_h(longint'(high_len));
      m_l      <= eff_l(longint'(period), eff_h(longint'(high_len)));
      m_n      <= longint'(burst_len);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_pulse_out", longint'(pulse_out), longint'(m_pulse(ecount)));
      chk("model_busy",      longint'(busy),      longint'(m_busy(ecount)));
      chk("model_done",      longint'(done),      longint'(m_done(ecount)));
      chk("model_pulse_cnt", longint'(pulse_cnt), m_cnt(ecount));
    end
  end

  // Called at a negedge; returns at the negedge of the first active cycle.
  task automatic start_train(input int per, input int hl, input int bl);
    start     = 1'b1;
    period    = CW'(per);
    high_len  = CW'(hl);
    burst_len = BW'(bl);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_done(input int n0, input int limit, output int cyc, output int rises);
    bit prev;
    cyc   = n0;
    rises = (n0 == 1 && pulse_out) ? 1 : 0;
    prev  = pulse_out;
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (pulse_out && !prev) rises++;
      prev = pulse_out;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int cyc, rises;
    repeat (3) @(negedge clk);
    chk("reset_pulse_out", longint'(pulse_out), 0);
    chk("reset_busy",      longint'(busy),      0);
    chk("reset_done",      longint'(done),      0);
    chk("reset_pulse_cnt", longint'(pulse_cnt), 0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Burst of 3, 4 high / 6 low.
    start_train(10, 4, 3);
    chk("t1_first_high", longint'(pulse_out), 1);
    chk("t1_first_cnt",  longint'(pulse_cnt), 1);
    run_to_done(1, 200, cyc, rises);
    chk("t1_done_cycle", cyc, 31);
    chk("t1_rises",      rises, 3);
    chk("t1_cnt",        longint'(pulse_cnt), 3);
    chk("t1_busy_low",   longint'(busy), 0);
    @(negedge clk);
    chk("t1_done_one_cycle", longint'(done), 0);

    // Clamped phases: H=4, L=4.
    start_train(3, 1, 2);
    run_to_done(1, 200, cyc, rises);
    chk("t2_done_cycle", cyc, 17);
    chk("t2_rises",      rises, 2);

    // Start and config change mid-train are ignored.
    start_train(10, 4, 2);
    repeat (3) @(negedge clk);
    start = 1'b1; period = CW'(20); high_len = CW'(9); burst_len = BW'(7);
    @(negedge clk);
    start = 1'b0;
    run_to_done(5, 200, cyc, rises);
    chk("t3_done_cycle", cyc, 21);
    chk("t3_cnt",        longint'(pulse_cnt), 2);

    // Start and stop together while idle.
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_idle_busy", longint'(busy), 0);
    chk("t4_idle_cnt",  longint'(pulse_cnt), 2);

    // Stop in the 2nd high cycle of pulse 2.
    start_train(10, 4, 5);
    repeat (11) @(negedge clk);
    chk("t5_high_before_stop", longint'(pulse_out), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t5_abort_pulse", longint'(pulse_out), 0);
    chk("t5_abort_done",  longint'(done), 1);
    chk("t5_abort_busy",  longint'(busy), 0);
    chk("t5_abort_cnt",   longint'(pulse_cnt), 2);
    start_train(10, 4, 1);
    chk("t5_restart_busy", longint'(busy), 1);
    chk("t5_restart_cnt",  longint'(pulse_cnt), 1);
    run_to_done(1, 200, cyc, rises);
    chk("t5_restart_done", cyc, 11);

    // Continuous train through a counter wrap.
    @(negedge clk);
    start_train(8, 4, 0);
    repeat (2040) @(negedge clk);
    chk("t6_wrap_pulse", longint'(pulse_out), 1);
    chk("t6_wrap_cnt",   longint'(pulse_cnt), 0);
    repeat (16) @(negedge clk);
    chk("t6_after_wrap_cnt",  longint'(pulse_cnt), 2);
    chk("t6_after_wrap_busy", longint'(busy), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t6_stop_done", longint'(done), 1);

    // Asynchronous reset mid-HIGH.
    @(negedge clk);
    start_train(10, 6, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_pulse", longint'(pulse_out), 0);
    chk("t7_rst_busy",  longint'(busy), 0);
    chk("t7_rst_cnt",   longint'(pulse_cnt), 0);
    chk("t7_rst_done",  longint'(done), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t7_no_done", longint'(done), 0);
    start_train(10, 4, 1);
    run_to_done(1, 200, cyc, rises);
    chk("t7_post_rst_done", cyc, 11);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Programmable pulse-train source for the step generator's external pulse input. It emits a burst of N pulses, or a continuous train, with a programmable period and high time measured in system clocks. It is used on-board as a self-test stimulus and as a bench driver, so the step counter can be exercised without an external function generator. A start/stop control interface and a busy/done status interface let a control FSM or switch logic sequence bursts.

## Interface

Parameters:
- CNT_W, 32, width of the period and high-time fields, in clock cycles.
- BURST_W, 16, width of the burst-length field and the pulse counter.
- MIN_PHASE, 4, minimum length in cycles of either phase (high or low) after clamping.

Ports:
- clk  in  1  100 MHz system clock; every flop is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; latches the config and begins a train.
- stop  in  1  one-cycle abort request.
- period  in  CNT_W  full pulse period in cycles; sampled only on an accepted start.
- high_len  in  CNT_W  high-phase length in cycles; sampled only on an accepted start.
- burst_len  in  BURST_W  number of pulses; 0 means continuous. Sampled only on an accepted start.
- pulse_out  out  1  generated pulse train, registered and glitch-free.
- busy  out  1  high while a train is active.
- done  out  1  one-cycle strobe when a train ends, whether it completes or is aborted.
- pulse_cnt  out  BURST_W  count of rising edges issued in the current or last train.

## Operation

- FSM states: IDLE, HIGH, LOW.
- Effective phase lengths, computed once at start and held in registers:
  - H = max(high_len, MIN_PHASE).
  - L = MIN_PHASE if period ≤ H + MIN_PHASE - 1, else period − H.
  - Compute L without underflow: compare before subtracting.
- IDLE:
  - An accepted start latches H, L and burst_len.
  - It clears pulse_cnt, sets busy, and moves to HIGH.
- HIGH:
  - Entry increments pulse_cnt; pulse_cnt wraps from 2^BURST_W−1 to 0.
  - pulse_out is 1 for exactly H cycles, then the FSM moves to LOW.
- LOW:
  - pulse_out is 0 for exactly L cycles.
  - At the end of LOW, if burst_len≠0 and pulse_cnt==burst_len: go to IDLE, busy=0, done=1 for one cycle.
  - Otherwise go to HIGH.
- The phase counter is a single down-counter, reloaded with H−1 or L−1 on each transition.
- start while busy: ignored. Config inputs have no effect mid-train.
- stop while busy: abort.
  - The next cycle has pulse_out=0, busy=0, done=1, and state IDLE.
  - pulse_cnt holds its value.
- stop while idle: ignored.
- start and stop in the same cycle: stop wins.
  - If idle, nothing happens.
  - If busy, the train aborts.
- Reset in mid-operation: immediate return to the reset values; no done strobe.

## Timing

- Reset values: pulse_out=0, busy=0, done=0, pulse_cnt=0, state=IDLE.
- Start sampled at edge t:
  - busy=1 and pulse_out=1 from cycle t+1, so start-to-first-edge latency is 1 cycle.
  - The first rising edge has pulse_cnt=1 in the same cycle.
- Pulse k rises at t+1+(k−1)(H+L) and falls H cycles later.
- Burst of N pulses:
  - done=1 and busy=0 in cycle t+1+N(H+L).
  - pulse_out is already 0 there, so there is no trailing high.
- done lasts exactly one cycle; it is never asserted together with busy=1.
- A new start is accepted in the same cycle that done is high, because busy is already 0.
- All outputs are registered; there is no combinational path from the inputs to the outputs.

## Test plan

- Reset, then start with period=10, high_len=4, burst_len=3 → three pulses of 4 high / 6 low. Edges at cycles t+1, t+11, t+21; pulse_cnt=3; done at t+31; busy low from t+31.
- high_len=1, period=3, burst_len=2 → clamped H=4, L=4. Period is 8 cycles and done arrives at t+17.
- burst_len=0, period=8, high_len=4 → continuous train. Run 2^16+2 pulses: pulse_cnt wraps to 0 then reaches 2; busy stays 1 throughout.
- stop in the 2nd cycle of the high phase of pulse 2 → pulse_out=0, done=1 and busy=0 the next cycle; pulse_cnt=2. A subsequent start begins a fresh train with pulse_cnt=1.
- start asserted mid-train, start and stop in the same cycle while idle, and a config change mid-train → train timing is unchanged, idle stays idle, and no done is raised.
- rst asserted asynchronously mid-HIGH (between clock edges) → pulse_out, busy and pulse_cnt go to 0 immediately, with no done strobe.
